// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : retire_trace_buffer
// Brief   : FIFO of core retire records drained as 4/6-word trace packets.
// Revision: 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_data_o,
  output logic                     out_last_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drop_cnt_o,
  input  logic                     clr_drop_i
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 14 + 5 * XLEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_PC    = 3'd2,
    S_INSTR = 3'd3,
    S_RDATA = 3'd4,
    S_MADDR = 3'd5,
    S_MDATA = 3'd6
  } state_t;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_seq;
  logic [15:0]      r_drop;
  logic             r_valid;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [REC_W-1:0] w_head_rec;
  logic [7:0]       w_h_seq;
  logic             w_h_mw;
  logic [4:0]       w_h_rd;
  logic [XLEN-1:0]  w_h_pc;
  logic [XLEN-1:0]  w_h_instr;
  logic [XLEN-1:0]  w_h_rdata;
  logic [XLEN-1:0]  w_h_maddr;
  logic [XLEN-1:0]  w_h_mdata;
  logic [XLEN-1:0]  w_hdr;
  logic             w_fire;
  logic             w_release;
  logic             w_capture;
  logic             w_drop;
  state_t           w_after_rel;

  assign w_head_rec = r_mem[r_head];
  assign w_h_seq    = w_head_rec[5*XLEN+13 : 5*XLEN+6];
  assign w_h_mw     = w_head_rec[5*XLEN+5];
  assign w_h_rd     = w_head_rec[5*XLEN+4 : 5*XLEN];
  assign w_h_pc     = w_head_rec[5*XLEN-1 : 4*XLEN];
  assign w_h_instr  = w_head_rec[4*XLEN-1 : 3*XLEN];
  assign w_h_rdata  = w_head_rec[3*XLEN-1 : 2*XLEN];
  assign w_h_maddr  = w_head_rec[2*XLEN-1 : XLEN];
  assign w_h_mdata  = w_head_rec[XLEN-1 : 0];

  assign w_hdr = XLEN'({w_h_seq, w_h_mw, w_h_rd, 15'b0, (w_h_mw ? 3'd6 : 3'd4)});

  assign w_fire    = r_valid & out_ready_i;
  assign w_release = w_fire & (((r_state == S_RDATA) & ~w_h_mw) | (r_state == S_MDATA));
  // A full FIFO can still accept when the head leaves on the same edge.
  assign w_capture = update_i & ((r_count < CW'(DEPTH)) | w_release);
  assign w_drop    = update_i & ~w_capture;

  assign w_after_rel = ((r_count > CW'(1)) | w_capture) ? S_HDR : S_IDLE;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_HDR;
      S_HDR:   if (w_fire) w_state_nxt = S_PC;
      S_PC:    if (w_fire) w_state_nxt = S_INSTR;
      S_INSTR: if (w_fire) w_state_nxt = S_RDATA;
      S_RDATA: if (w_fire) w_state_nxt = w_h_mw ? S_MADDR : w_after_rel;
      S_MADDR: if (w_fire) w_state_nxt = S_MDATA;
      S_MDATA: if (w_fire) w_state_nxt = w_after_rel;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_data_o = '0;
    out_last_o = 1'b0;
    case (r_state)
      S_HDR:   out_data_o = w_hdr;
      S_PC:    out_data_o = w_h_pc;
      S_INSTR: out_data_o = w_h_instr;
      S_RDATA: begin
        out_data_o = w_h_rdata;
        out_last_o = ~w_h_mw;
      end
      S_MADDR: out_data_o = w_h_maddr;
      S_MDATA: begin
        out_data_o = w_h_mdata;
        out_last_o = 1'b1;
      end
      default: begin
        out_data_o = '0;
        out_last_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      r_mem[r_tail] <= {r_seq, mem_wrt_i, reg_addr_i, pc_i, instr_i,
                        reg_data_i, mem_addr_i, mem_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_tail <= r_tail + AW'(1);
        r_seq  <= r_seq + 8'd1;
      end
      if (w_release) r_head <= r_head + AW'(1);
      case ({w_capture, w_release})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (clr_drop_i)
        r_drop <= w_drop ? 16'd1 : 16'd0;
      else if (w_drop && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  assign out_valid_o = r_valid;
  assign count_o     = r_count;
  assign drop_cnt_o  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_retire_trace_buffer
// Brief   : Scoreboard bench for retire_trace_buffer packet stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              update_i = 1'b0;
  logic [XLEN-1:0]   pc_i = '0;
  logic [XLEN-1:0]   instr_i = '0;
  logic [4:0]        reg_addr_i = '0;
  logic [XLEN-1:0]   reg_data_i = '0;
  logic [XLEN-1:0]   mem_addr_i = '0;
  logic [XLEN-1:0]   mem_data_i = '0;
  logic              mem_wrt_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [XLEN-1:0]   out_data_o;
  logic              out_last_o;
  logic [4:0]        count_o;
  logic [15:0]       drop_cnt_o;
  logic              clr_drop_i = 1'b0;

  retire_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .update_i    (update_i),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .reg_addr_i  (reg_addr_i),
    .reg_data_i  (reg_data_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_wrt_i   (mem_wrt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .count_o     (count_o),
    .drop_cnt_o  (drop_cnt_o),
    .clr_drop_i  (clr_drop_i)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] sb[$];
  logic [7:0]  tb_seq = 8'd0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  function automatic logic [31:0] hdr(input logic [7:0] s, input logic mw, input logic [4:0] rd);
    return {s, mw, rd, 15'b0, (mw ? 3'd6 : 3'd4)};
  endfunction

  // Stream monitor: pops expectations on every accepted word, and checks hold under stall.
  always @(negedge clk) begin
    logic [32:0] exp_w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_vec++;
        if (!(out_valid_o && out_data_o == prev_data && out_last_o == prev_last)) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b data=%08h last=%0b, need valid=1 data=%08h last=%0b",
                   out_valid_o, out_data_o, out_last_o, prev_data, prev_last);
        end
      end
      if (out_valid_o && out_ready_i) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stream_word: got unexpected data=%08h last=%0b, need no word", out_data_o, out_last_o);
        end else begin
          exp_w = sb.pop_front();
          if (out_data_o != exp_w[31:0] || out_last_o != exp_w[32]) begin
            n_err++;
            $display("FAIL stream_word: got data=%08h last=%0b, need data=%08h last=%0b",
                     out_data_o, out_last_o, exp_w[31:0], exp_w[32]);
          end
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %08h, need %08h", name, act, exp_v);
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                      input logic [31:0] rdata, input logic mw, input logic [31:0] maddr,
                      input logic [31:0] mdata, input bit expect_accept);
    update_i   = 1'b1;
    pc_i       = pc;
    instr_i    = instr;
    reg_addr_i = rd;
    reg_data_i = rdata;
    mem_wrt_i  = mw;
    mem_addr_i = maddr;
    mem_data_i = mdata;
    if (expect_accept) begin
      sb.push_back({1'b0, hdr(tb_seq, mw, rd)});
      sb.push_back({1'b0, pc});
      sb.push_back({1'b0, instr});
      sb.push_back({~mw, rdata});
      if (mw) begin
        sb.push_back({1'b0, maddr});
        sb.push_back({1'b1, mdata});
      end
      tb_seq++;
    end
    tick();
    update_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    tb_seq = 8'd0;
  endtask

  task automatic wait_drain(input bit toggle_ready);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !out_valid_o) begin
        done = 1'b1;
        break;
      end
      if (toggle_ready) out_ready_i = ~out_ready_i;
      tick();
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d words pending, need 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, need finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    // Reset state
    do_reset();
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_last",  {31'b0, out_last_o},  32'd0);
    chk("rst_data",  out_data_o,           32'd0);
    chk("rst_count", {27'b0, count_o},     32'd0);
    chk("rst_drop",  {16'b0, drop_cnt_o},  32'd0);

    // Single register write: HDR presented two cycles after the pulse
    out_ready_i = 1'b1;
    send(32'h8000_0000, 32'h0050_0093, 5'd1, 32'h5, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t1_count", {27'b0, count_o}, 32'd1);
    chk("t1_valid_early", {31'b0, out_valid_o}, 32'd0);
    tick();
    chk("t1_valid", {31'b0, out_valid_o}, 32'd1);
    chk("t1_hdr", out_data_o, 32'h0004_0004);
    wait_drain(1'b0);
    chk("t1_count_end", {27'b0, count_o}, 32'd0);

    // Store record
    do_reset();
    out_ready_i = 1'b1;
    send(32'h8000_0004, 32'h00A1_2023, 5'd0, 32'h0, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 1'b1);
    tick();
    chk("t2_hdr", out_data_o, 32'h0080_0006);
    wait_drain(1'b0);

    // Backpressure with ready toggling over three records
    do_reset();
    out_ready_i = 1'b0;
    send(32'h8000_0010, 32'h0010_0113, 5'd2, 32'h11, 1'b0, 32'h0, 32'h0, 1'b1);
    send(32'h8000_0014, 32'h0020_0193, 5'd3, 32'h22, 1'b0, 32'h0, 32'h0, 1'b1);
    send(32'h8000_0018, 32'h0030_0213, 5'd4, 32'h33, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t3_count_full", {27'b0, count_o}, 32'd3);
    wait_drain(1'b1);
    chk("t3_count_end", {27'b0, count_o}, 32'd0);

    // Overflow: DEPTH+3 captures with the sink stalled
    do_reset();
    out_ready_i = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++)
      send(32'h1000 + 32'(4 * k), 32'(k), 5'(k), 32'(3 * k), 1'b0, 32'h0, 32'h0, k < DEPTH);
    chk("t4_count", {27'b0, count_o}, 32'd16);
    chk("t4_drop", {16'b0, drop_cnt_o}, 32'd3);
    clr_drop_i = 1'b1;
    tick();
    clr_drop_i = 1'b0;
    chk("t4_drop_clr", {16'b0, drop_cnt_o}, 32'd0);
    out_ready_i = 1'b1;
    wait_drain(1'b0);

    // Full FIFO with a capture on the release edge
    do_reset();
    out_ready_i = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      send(32'h2000 + 32'(4 * k), 32'(k + 100), 5'(k), 32'(k), 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t5_count_full", {27'b0, count_o}, 32'd16);
    out_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_o && out_last_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t5_reach_rdata", {31'b0, found}, 32'd1);
    send(32'h3000, 32'hCAFE_0001, 5'd7, 32'h77, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t5_count_hold", {27'b0, count_o}, 32'd16);
    chk("t5_drop", {16'b0, drop_cnt_o}, 32'd0);
    chk("t5_valid", {31'b0, out_valid_o}, 32'd1);
    chk("t5_next_hdr", out_data_o, hdr(8'd1, 1'b0, 5'd1));
    wait_drain(1'b0);

    // Reset in the middle of a packet
    do_reset();
    out_ready_i = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++)
      send(32'h4000 + 32'(4 * k), 32'h5500_0000 + 32'(k), 5'(k), 32'(k), 1'b0, 32'h0, 32'h0, k < DEPTH);
    chk("t6_drop_pre", {16'b0, drop_cnt_o}, 32'd1);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("t6_in_instr", out_data_o, 32'h5500_0000);
    rst = 1'b1;
    tick();
    chk("t6_valid", {31'b0, out_valid_o}, 32'd0);
    chk("t6_last",  {31'b0, out_last_o},  32'd0);
    chk("t6_count", {27'b0, count_o},     32'd0);
    chk("t6_drop",  {16'b0, drop_cnt_o},  32'd0);
    rst = 1'b0;
    sb.delete();
    tb_seq = 8'd0;
    send(32'h8000_0200, 32'h0000_0013, 5'd9, 32'h99, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("t6_seq0_hdr", out_data_o, hdr(8'd0, 1'b0, 5'd9));
    wait_drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
